// File: rtl/hazard_if.sv
// Pipeline hazard bundle: register numbers, write enables, memory handshake,
// plus the stall/flush/forward controls and status returned by the controller.
interface hazard_if;
    logic [4:0]  RsD, RtD, RsE, RtE;
    logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemReqM, MemReadyM, PCSrcE;
    logic        stalF, stalD, stalE, stalM;
    logic        flushD, flushE, flushW;
    logic [1:0]  forwardAE, forwardBE;
    logic        MemStartM, mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM, PCSrcE,
        input  stalF, stalD, stalE, stalM, flushD, flushE, flushW,
               forwardAE, forwardBE, MemStartM, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemReadyM, PCSrcE,
        output stalF, stalD, stalE, stalM, flushD, flushE, flushW,
               forwardAE, forwardBE, MemStartM, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use and branch
// handling, and a data-memory wait FSM with watchdog and saturating event counters.
module hazard_ctrl #(
    parameter int unsigned WD_MAX = 255
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              mem_err;
    logic              wd_fire, memstall, lwstall;
    logic              stal_f, flush_e;
    logic              unused_e_stage;

    // E-stage write info is part of the bundle but not needed by these rules.
    assign unused_e_stage = ^{bus.WriteRegE, bus.RegWriteE};

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             wr_m,
        input logic [REG_W-1:0] reg_m,
        input logic             wr_w,
        input logic [REG_W-1:0] reg_w
    );
        if (wr_m && (reg_m != '0) && (reg_m == src))      return 2'b10;
        else if (wr_w && (reg_w != '0) && (reg_w == src)) return 2'b01;
        else                                              return 2'b00;
    endfunction

    // Next state, watchdog and all combinational controls; reset forces controls low.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        wd_fire       = 1'b0;
        memstall      = 1'b0;
        lwstall       = 1'b0;
        stal_f        = 1'b0;
        flush_e       = 1'b0;
        bus.stalF     = 1'b0;
        bus.stalD     = 1'b0;
        bus.stalE     = 1'b0;
        bus.stalM     = 1'b0;
        bus.flushD    = 1'b0;
        bus.flushE    = 1'b0;
        bus.flushW    = 1'b0;
        bus.forwardAE = 2'b00;
        bus.forwardBE = 2'b00;
        bus.MemStartM = 1'b0;

        case (state)
            IDLE: begin
                if (bus.MemReqM) begin
                    bus.MemStartM = ~reset;
                    wait_cnt_next = '0;
                    state_next    = bus.MemReadyM ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (bus.MemReadyM) begin
                    state_next = DONE;
                end else if (wait_cnt == WAIT_W'(WD_MAX)) begin
                    wd_fire    = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        memstall = bus.MemReqM & ~bus.MemReadyM &
                   ((state == IDLE) | ((state == WAIT) & ~wd_fire));
        lwstall  = bus.MemtoRegE & (bus.RtE != '0) &
                   ((bus.RtE == bus.RsD) | (bus.RtE == bus.RtD));

        if (!reset) begin
            bus.forwardAE = fwd_sel(bus.RsE, bus.RegWriteM, bus.WriteRegM,
                                    bus.RegWriteW, bus.WriteRegW);
            bus.forwardBE = fwd_sel(bus.RtE, bus.RegWriteM, bus.WriteRegM,
                                    bus.RegWriteW, bus.WriteRegW);
            // Memory wait dominates; a taken branch squashes a wrong-path load-use stall.
            if (memstall) begin
                bus.stalF  = 1'b1;
                bus.stalD  = 1'b1;
                bus.stalE  = 1'b1;
                bus.stalM  = 1'b1;
                bus.flushW = 1'b1;
            end else if (bus.PCSrcE) begin
                bus.flushD = 1'b1;
                bus.flushE = 1'b1;
            end else if (lwstall) begin
                bus.stalF  = 1'b1;
                bus.stalD  = 1'b1;
                bus.flushE = 1'b1;
            end
        end
        stal_f  = bus.stalF;
        flush_e = bus.flushE;
    end

    // State, watchdog, sticky error and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (wd_fire) mem_err <= 1'b1;
            if (stal_f && (stall_cnt != '1))  stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_e && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.mem_err   = mem_err;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural pipeline-hazard model.
module tb_hazard_ctrl;
    localparam int unsigned WD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_if hif();

    hazard_ctrl #(.WD_MAX(WD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    // Behavioural model: access outstanding / done-cycle flags, waited cycles, counts.
    bit m_busy, m_done, m_err;
    int m_wait, m_stall, m_flush;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (hif.RegWriteM && hif.WriteRegM != 0 && hif.WriteRegM == src) return 2'b10;
        if (hif.RegWriteW && hif.WriteRegW != 0 && hif.WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    // {stalF,stalD,stalE,stalM,flushD,flushE,flushW,MemStartM,forwardAE,forwardBE}
    function automatic logic [11:0] ref_ctrl();
        logic [11:0] r;
        bit idle, mem, lw;
        r    = '0;
        idle = !m_busy && !m_done;
        mem  = hif.MemReqM && !hif.MemReadyM && (idle || (m_busy && m_wait != int'(WD)));
        lw   = hif.MemtoRegE && hif.RtE != 0 && (hif.RtE == hif.RsD || hif.RtE == hif.RtD);
        if (reset) return r;
        r[3:2] = ref_fwd(hif.RsE);
        r[1:0] = ref_fwd(hif.RtE);
        r[4]   = idle && hif.MemReqM;
        if (mem)             begin r[11:8] = 4'hF; r[5] = 1'b1; end
        else if (hif.PCSrcE) begin r[7] = 1'b1; r[6] = 1'b1; end
        else if (lw)         begin r[11] = 1'b1; r[10] = 1'b1; r[6] = 1'b1; end
        return r;
    endfunction

    function automatic logic [11:0] got_ctrl();
        return {hif.stalF, hif.stalD, hif.stalE, hif.stalM, hif.flushD, hif.flushE,
                hif.flushW, hif.MemStartM, hif.forwardAE, hif.forwardBE};
    endfunction

    always @(posedge clk) begin
        logic [11:0] c;
        c = ref_ctrl();
        if (reset) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (c[11] && m_stall < 65535) m_stall++;
            if (c[6]  && m_flush < 65535) m_flush++;
            if (m_done) m_done = 0;
            else if (m_busy) begin
                if (hif.MemReadyM)            begin m_busy = 0; m_done = 1; end
                else if (m_wait == int'(WD))  begin m_err = 1; m_busy = 0; m_done = 1; end
                else m_wait++;
            end else if (hif.MemReqM) begin
                if (hif.MemReadyM) m_done = 1;
                else begin m_busy = 1; m_wait = 0; end
            end
        end
    end

    task automatic clear_inputs();
        hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
        hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
        hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemtoRegE = 0; hif.MemReqM = 0; hif.MemReadyM = 0; hif.PCSrcE = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            hif.MemReqM = 1; hif.MemtoRegE = 1; hif.RtE = 3; hif.RsD = 3;
            hif.RegWriteM = 1; hif.WriteRegM = 3; hif.RsE = 3; hif.PCSrcE = (i % 2 == 1);
            @(negedge clk);
            n_tests++;
            if (got_ctrl() !== 12'h000) begin
                n_fail++; $display("FAIL reset_ctrl got=%h exp=000", got_ctrl());
            end
            n_tests++;
            if ({hif.stall_cnt, hif.flush_cnt, hif.mem_err} !== 33'h0) begin
                n_fail++; $display("FAIL reset_status got=%h/%h/%b exp=0/0/0",
                                   hif.stall_cnt, hif.flush_cnt, hif.mem_err);
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        reset = 0;
        @(negedge clk);
        n_tests++;
        if (hif.MemStartM !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_start got=%b exp=0", hif.MemStartM);
        end
    endtask

    task automatic test_forward();
        @(posedge clk); #1;
        hif.RegWriteM = 1; hif.WriteRegM = 5; hif.RsE = 5;
        hif.RegWriteW = 1; hif.WriteRegW = 5; hif.RtE = 9;
        @(negedge clk);
        n_tests++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_m_priority got=%b%b exp=1000", hif.forwardAE, hif.forwardBE);
        end
        @(posedge clk); #1;
        hif.WriteRegM = 0;
        @(negedge clk);
        n_tests++;
        if (hif.forwardAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_m_r0 got=%b exp=01", hif.forwardAE);
        end
        @(posedge clk); #1;
        hif.RtE = 5; hif.WriteRegM = 5; hif.RegWriteM = 0;
        @(negedge clk);
        n_tests++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b0101) begin
            n_fail++; $display("FAIL fwd_w_both got=%b%b exp=0101", hif.forwardAE, hif.forwardBE);
        end
        @(posedge clk); #1;
        hif.RegWriteW = 0;
        @(negedge clk);
        n_tests++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_none got=%b%b exp=0000", hif.forwardAE, hif.forwardBE);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_lwstall();
        hif.MemtoRegE = 1; hif.RtE = 3; hif.RsD = 3;
        @(negedge clk);
        n_tests++;
        if (got_ctrl() !== 12'hC40 || hif.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL lw_rs got=%h cnt=%0d exp=c40 cnt=0", got_ctrl(), hif.stall_cnt);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (got_ctrl() !== 12'h000 || hif.stall_cnt !== 16'd1 || hif.flush_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lw_release got=%h cnt=%0d/%0d exp=000 cnt=1/1",
                               got_ctrl(), hif.stall_cnt, hif.flush_cnt);
        end
        @(posedge clk); #1;
        hif.MemtoRegE = 1; hif.RtE = 0; hif.RsD = 0; hif.RtD = 0;
        @(negedge clk);
        n_tests++;
        if (got_ctrl() !== 12'h000) begin
            n_fail++; $display("FAIL lw_r0 got=%h exp=000", got_ctrl());
        end
        @(posedge clk); #1;
        hif.RtE = 7; hif.RtD = 7; hif.RsD = 1;
        @(negedge clk);
        n_tests++;
        if (got_ctrl() !== 12'hC40) begin
            n_fail++; $display("FAIL lw_rt got=%h exp=c40", got_ctrl());
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_branch_over_lw();
        hif.MemtoRegE = 1; hif.RtE = 3; hif.RsD = 3; hif.PCSrcE = 1;
        @(negedge clk);
        n_tests++;
        if (got_ctrl() !== 12'h0C0) begin
            n_fail++; $display("FAIL branch_lw got=%h exp=0c0", got_ctrl());
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (hif.stall_cnt !== 16'd2 || hif.flush_cnt !== 16'd3) begin
            n_fail++; $display("FAIL branch_cnt got=%0d/%0d exp=2/3", hif.stall_cnt, hif.flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 6; i++) begin
            logic s;
            @(posedge clk); #1;
            hif.MemReqM = (i < 5); hif.MemReadyM = (i == 3); hif.PCSrcE = (i == 0);
            hif.RegWriteM = 1; hif.WriteRegM = 5; hif.RsE = 5;
            s = (i < 3);
            @(negedge clk);
            n_tests++;
            if (got_ctrl() !== {{4{s}}, 1'b0, 1'b0, s, (i == 0), 2'b10, 2'b00}) begin
                n_fail++; $display("FAIL mem_wait_c%0d got=%h exp=%h", i, got_ctrl(),
                                   {{4{s}}, 1'b0, 1'b0, s, (i == 0), 2'b10, 2'b00});
            end
        end
        n_tests++;
        if (hif.stall_cnt !== 16'd5 || hif.flush_cnt !== 16'd3) begin
            n_fail++; $display("FAIL mem_wait_cnt got=%0d/%0d exp=5/3", hif.stall_cnt, hif.flush_cnt);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 8; i++) begin
            logic s;
            @(posedge clk); #1;
            hif.MemReqM = (i < 7);
            s = (i <= 4);
            @(negedge clk);
            n_tests++;
            if ({hif.stalF, hif.stalM, hif.flushW, hif.MemStartM, hif.mem_err} !==
                {s, s, s, (i == 0), (i >= 6)}) begin
                n_fail++; $display("FAIL watchdog_c%0d got=%b%b%b%b%b exp=%b%b%b%b%b", i,
                                   hif.stalF, hif.stalM, hif.flushW, hif.MemStartM, hif.mem_err,
                                   s, s, s, (i == 0), (i >= 6));
            end
        end
        n_tests++;
        if (hif.stall_cnt !== 16'd10) begin
            n_fail++; $display("FAIL watchdog_cnt got=%0d exp=10", hif.stall_cnt);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset         = ($urandom_range(0, 63) == 0);
            hif.RsD       = 5'($urandom_range(0, 3));
            hif.RtD       = 5'($urandom_range(0, 3));
            hif.RsE       = 5'($urandom_range(0, 3));
            hif.RtE       = 5'($urandom_range(0, 3));
            hif.WriteRegE = 5'($urandom_range(0, 3));
            hif.WriteRegM = 5'($urandom_range(0, 3));
            hif.WriteRegW = 5'($urandom_range(0, 3));
            hif.RegWriteE = 1'($urandom_range(0, 1));
            hif.RegWriteM = 1'($urandom_range(0, 1));
            hif.RegWriteW = 1'($urandom_range(0, 1));
            hif.MemtoRegE = 1'($urandom_range(0, 1));
            hif.MemReqM   = ($urandom_range(0, 2) == 0);
            hif.MemReadyM = ($urandom_range(0, 3) == 0);
            hif.PCSrcE    = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            n_tests++;
            if (got_ctrl() !== ref_ctrl()) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", i, got_ctrl(), ref_ctrl());
            end
            n_tests++;
            if (hif.stall_cnt !== 16'(m_stall) || hif.flush_cnt !== 16'(m_flush) || hif.mem_err !== m_err) begin
                n_fail++; $display("FAIL rand_status cyc=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i,
                                   hif.stall_cnt, hif.flush_cnt, hif.mem_err, m_stall, m_flush, m_err);
            end
        end
        @(posedge clk); #1;
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_saturation();
        hif.MemtoRegE = 1; hif.RtE = 4; hif.RtD = 4;
        repeat (70000) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        n_tests++;
        if (hif.stall_cnt !== 16'hFFFF || hif.flush_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL saturate got=%h/%h exp=ffff/ffff", hif.stall_cnt, hif.flush_cnt);
        end
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        n_tests++;
        if ({hif.stall_cnt, hif.flush_cnt, hif.mem_err, hif.MemStartM} !== 34'h0) begin
            n_fail++; $display("FAIL sat_reset got=%h/%h/%b/%b exp=0/0/0/0",
                               hif.stall_cnt, hif.flush_cnt, hif.mem_err, hif.MemStartM);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_lwstall();
        test_branch_over_lw();
        test_mem_wait();
        test_watchdog();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
